// File: rtl/dft_mac_sequencer.sv
// dft_mac_sequencer: frame buffer and operand sequencer for a 32-point direct-
// summation DFT on an external pair of MAC accumulators (real / imaginary).
// Buffers 32 Q.8 samples, then for each bin k streams x[n] and W^(k*n) to the
// MACs, issuing the accumulator-clear strobe and flagging finished bins.
// Build option: DFT_SEQ_HALF_SPECTRUM_EN computes bins 0..16 only.
module dft_mac_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 32
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b_re,
  output logic [DATA_WIDTH-1:0] mac_b_im,
  output logic                  mac_sload,
  output logic                  bin_valid,
  output logic [4:0]            bin_idx,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
  localparam logic [AW-1:0] K_LAST = AW'(16);
`else
  localparam logic [AW-1:0] K_LAST = AW'(N - 1);
`endif

  typedef enum logic [1:0] {LOAD, PRIME, RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         k_q, k_d;
  logic [AW-1:0]         n_q, n_d;
  logic [AW-1:0]         tw_q, tw_d;
  logic [DATA_WIDTH-1:0] frame_q [N];
  logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
  logic [DATA_WIDTH-1:0] mac_b_re_q, mac_b_re_d;
  logic [DATA_WIDTH-1:0] mac_b_im_q, mac_b_im_d;
  logic                  mac_sload_q, mac_sload_d;
  logic                  bin_valid_q, bin_valid_d;
  logic [4:0]            bin_idx_q, bin_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;
  logic                  wr_en;
  logic                  run_d;

  // Q8.8 cosine table folded from one quarter wave: round(256*cos(2*pi*m/32)).
  function automatic logic [DATA_WIDTH-1:0] cos_rom(input logic [4:0] m);
    logic [3:0] f;
    logic       neg;
    int         v;
    if (m <= 5'd8) begin
      f = m[3:0];             neg = 1'b0;
    end else if (m <= 5'd16) begin
      f = 4'(5'd16 - m);      neg = 1'b1;
    end else if (m <= 5'd24) begin
      f = 4'(m - 5'd16);      neg = 1'b1;
    end else begin
      f = 4'(6'd32 - {1'b0, m}); neg = 1'b0;
    end
    case (f)
      4'd0:    v = 256;
      4'd1:    v = 251;
      4'd2:    v = 237;
      4'd3:    v = 213;
      4'd4:    v = 181;
      4'd5:    v = 142;
      4'd6:    v = 98;
      4'd7:    v = 50;
      default: v = 0;
    endcase
    return DATA_WIDTH'(neg ? -v : v);
  endfunction

  // -sin(2*pi*m/32) equals -cos(2*pi*(m-8)/32); the 5-bit subtract wraps mod 32.
  function automatic logic [DATA_WIDTH-1:0] nsin_rom(input logic [4:0] m);
    return -cos_rom(m - 5'd8);
  endfunction

  assign in_ready = (state_q == LOAD);
  assign wr_en    = in_ready & in_valid;

  // Next-state, counter and registered-output computation. Outputs are derived
  // from the next counters so each registered term lines up with its RUN cycle.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    k_d      = k_q;
    n_d      = n_q;
    tw_d     = tw_q;
    case (state_q)
      LOAD: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == LAST) state_d = PRIME;
        end
      end
      PRIME: begin
        state_d = RUN;
        k_d     = '0;
        n_d     = '0;
        tw_d    = '0;
      end
      RUN: begin
        if (n_q == LAST) begin
          n_d  = '0;
          tw_d = '0;
          if (k_q == K_LAST) begin
            state_d = FLUSH;
            k_d     = '0;
          end else begin
            k_d = k_q + AW'(1);
          end
        end else begin
          n_d  = n_q + AW'(1);
          tw_d = tw_q + k_q;
        end
      end
      FLUSH: begin
        state_d  = LOAD;
        wr_ptr_d = '0;
      end
      default: state_d = LOAD;
    endcase

    run_d        = (state_d == RUN);
    mac_a_d      = run_d ? frame_q[n_d]   : '0;
    mac_b_re_d   = run_d ? cos_rom(tw_d)  : '0;
    mac_b_im_d   = run_d ? nsin_rom(tw_d) : '0;
    mac_sload_d  = (state_d == PRIME) || (state_d == FLUSH) || (run_d && (n_d == LAST));
    bin_valid_d  = (state_q == RUN) && (n_q == LAST);
    bin_idx_d    = bin_valid_d ? 5'(k_q) : bin_idx_q;
    frame_done_d = (state_d == FLUSH);
    busy_d       = (state_d != LOAD);
  end

  // Sample buffer: written only while loading, read throughout RUN.
  always_ff @(posedge clk) begin
    if (wr_en) frame_q[wr_ptr_q] <= in_data;
  end

  // State, counters and registered outputs with asynchronous active-low clear.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      k_q          <= '0;
      n_q          <= '0;
      tw_q         <= '0;
      mac_a_q      <= '0;
      mac_b_re_q   <= '0;
      mac_b_im_q   <= '0;
      mac_sload_q  <= 1'b0;
      bin_valid_q  <= 1'b0;
      bin_idx_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      k_q          <= k_d;
      n_q          <= n_d;
      tw_q         <= tw_d;
      mac_a_q      <= mac_a_d;
      mac_b_re_q   <= mac_b_re_d;
      mac_b_im_q   <= mac_b_im_d;
      mac_sload_q  <= mac_sload_d;
      bin_valid_q  <= bin_valid_d;
      bin_idx_q    <= bin_idx_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mac_a      = mac_a_q;
  assign mac_b_re   = mac_b_re_q;
  assign mac_b_im   = mac_b_im_q;
  assign mac_sload  = mac_sload_q;
  assign bin_valid  = bin_valid_q;
  assign bin_idx    = bin_idx_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dft_mac_sequencer.sv
// Testbench for dft_mac_sequencer: drives directed frames, models the two
// external MACs (sload registered, zeroing one cycle later) and checks bins,
// timing, handshake and mid-frame reset. Honours DFT_SEQ_HALF_SPECTRUM_EN.
module tb_dft_mac_sequencer;

`ifdef DFT_SEQ_HALF_SPECTRUM_EN
  localparam int NB       = 17;
  localparam int DONE_OFF = 546;
  localparam int TOTAL    = 577;
`else
  localparam int NB       = 32;
  localparam int DONE_OFF = 1026;
  localparam int TOTAL    = 1057;
`endif

  logic        clk = 1'b0;
  logic        aclr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mac_a, mac_b_re, mac_b_im;
  logic        mac_sload, bin_valid, frame_done, busy;
  logic [4:0]  bin_idx;

  dft_mac_sequencer #(.DATA_WIDTH(32), .N(32)) dut (
    .clk(clk), .aclr(aclr), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mac_a(mac_a), .mac_b_re(mac_b_re), .mac_b_im(mac_b_im),
    .mac_sload(mac_sload), .bin_valid(bin_valid), .bin_idx(bin_idx),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // External MAC pair: operands accumulate each edge; registered sload zeroes next edge.
  longint acc_re, acc_im, p_re, p_im;
  logic   sload_r;
  assign p_re = longint'($signed(mac_a)) * longint'($signed(mac_b_re));
  assign p_im = longint'($signed(mac_a)) * longint'($signed(mac_b_im));
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sload_r <= 1'b0;
      acc_re  <= 0;
      acc_im  <= 0;
    end else begin
      sload_r <= mac_sload;
      acc_re  <= (sload_r ? 64'sd0 : acc_re) + p_re;
      acc_im  <= (sload_r ? 64'sd0 : acc_im) + p_im;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-frame capture written only by the monitor.
  logic [31:0] frame_in [32];
  int     frame_id = 0;
  int     seen_id  = 0;
  int     negcyc   = 0;
  int     xfer_cnt, first_xfer, last_xfer, rdy_bad;
  int     nbins, idx_bad, sp_bad, first_bin, prev_bin, done_cyc;
  bit     done_seen, done_last_bin;
  longint bin_re [32];
  longint bin_im [32];

  // Monitor sampling on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      negcyc++;
      if (seen_id != frame_id) begin
        seen_id = frame_id;
        xfer_cnt = 0; first_xfer = 0; last_xfer = 0; rdy_bad = 0;
        nbins = 0; idx_bad = 0; sp_bad = 0; first_bin = 0; prev_bin = 0;
        done_cyc = 0; done_seen = 0; done_last_bin = 0;
        for (int i = 0; i < 32; i++) begin bin_re[i] = 0; bin_im[i] = 0; end
      end
      if (in_valid && in_ready) begin
        if (xfer_cnt == 0)  first_xfer = negcyc;
        if (xfer_cnt == 31) last_xfer  = negcyc;
        xfer_cnt++;
      end
      if (busy && in_ready) rdy_bad++;
      if (bin_valid) begin
        if (int'(bin_idx) != nbins) idx_bad++;
        bin_re[bin_idx] = acc_re >>> 8;
        bin_im[bin_idx] = acc_im >>> 8;
        if (nbins == 0) first_bin = negcyc;
        else if (negcyc - prev_bin != 32) sp_bad++;
        prev_bin = negcyc;
        nbins++;
      end
      if (frame_done) begin
        done_cyc      = negcyc;
        done_seen     = 1;
        done_last_bin = bin_valid;
      end
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, "_in_ready"},   in_ready,   1);
    chk({nm, "_busy"},       busy,       0);
    chk({nm, "_mac_a"},      mac_a,      0);
    chk({nm, "_mac_b_re"},   mac_b_re,   0);
    chk({nm, "_mac_b_im"},   mac_b_im,   0);
    chk({nm, "_mac_sload"},  mac_sload,  0);
    chk({nm, "_bin_valid"},  bin_valid,  0);
    chk({nm, "_bin_idx"},    bin_idx,    0);
    chk({nm, "_frame_done"}, frame_done, 0);
  endtask

  // Called at #1 after a rising edge in LOAD; returns #1 after the last-transfer edge.
  task automatic load_frame(input string nm, input bit stall, input bit hold);
    int  i = 0;
    int  g = 0;
    bit  rdy;
    frame_id++;
    while (i < 32 && g < 500) begin
      if (stall && $urandom_range(0, 2) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = frame_in[i];
      end
      rdy = in_ready;
      @(posedge clk); #1;
      g++;
      if (in_valid && rdy) i++;
    end
    in_valid = hold;
    chk({nm, "_load_xfers"}, i, 32);
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 1500 && !done_seen; c++) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, "_done_seen"}, done_seen, 1);
  endtask

  task automatic frame_checks(input string nm);
    chk({nm, "_nbins"},       nbins,                 NB);
    chk({nm, "_idx_order"},   idx_bad,               0);
    chk({nm, "_spacing"},     sp_bad,                0);
    chk({nm, "_first_bin"},   first_bin - last_xfer, 34);
    chk({nm, "_done_time"},   done_cyc - last_xfer,  DONE_OFF);
    chk({nm, "_done_w_last"}, done_last_bin,         1);
    chk({nm, "_xfers"},       xfer_cnt,              32);
    chk({nm, "_rdy_busy"},    rdy_bad,               0);
  endtask

  task automatic impulse_values(input string nm);
    int bad = 0;
    for (int i = 0; i < NB; i++) if (bin_re[i] != 256 || bin_im[i] != 0) bad++;
    chk({nm, "_bins_bad"}, bad, 0);
    chk({nm, "_bin0_re"},  bin_re[0], 256);
    chk({nm, "_binL_re"},  bin_re[NB-1], 256);
  endtask

  task automatic set_frame(input int kind);
    for (int i = 0; i < 32; i++) begin
      case (kind)
        0:       frame_in[i] = (i == 0) ? 32'd256 : 32'd0;
        1:       frame_in[i] = 32'd256;
        default: frame_in[i] = (i == 1) ? 32'd256 : 32'd0;
      endcase
    end
  endtask

  initial begin
    int bound_bad;
    aclr     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    chk_reset("rst");
    aclr = 1'b1;
    @(posedge clk); #1;

    // Impulse at full rate, with PRIME and first RUN term inspected directly.
    set_frame(0);
    load_frame("imp", 1'b0, 1'b0);
    chk("prime_busy",     busy,      1);
    chk("prime_in_ready", in_ready,  0);
    chk("prime_sload",    mac_sload, 1);
    chk("prime_mac_a",    mac_a,     0);
    @(posedge clk); #1;
    chk("run0_mac_a",    mac_a,     256);
    chk("run0_b_re",     longint'($signed(mac_b_re)), 256);
    chk("run0_b_im",     longint'($signed(mac_b_im)), 0);
    chk("run0_sload",    mac_sload, 0);
    wait_done("imp");
    frame_checks("imp");
    chk("imp_total_cycles", done_cyc - first_xfer, TOTAL);
    impulse_values("imp");

    // DC frame.
    set_frame(1);
    load_frame("dc", 1'b0, 1'b0);
    wait_done("dc");
    frame_checks("dc");
    chk("dc_bin0_re", bin_re[0], 8192);
    chk("dc_bin0_im", bin_im[0], 0);
    bound_bad = 0;
    for (int i = 1; i < NB; i++)
      if (bin_re[i] > 32 || bin_re[i] < -32 || bin_im[i] > 32 || bin_im[i] < -32) bound_bad++;
    chk("dc_other_bound", bound_bad, 0);

    // Shifted impulse with random stalls, in_valid held high through RUN.
    set_frame(2);
    load_frame("sh", 1'b1, 1'b1);
    wait_done("sh");
    frame_checks("sh");
    chk("sh_b1_re",  bin_re[1],  251);
    chk("sh_b1_im",  bin_im[1],  -50);
    chk("sh_b4_re",  bin_re[4],  181);
    chk("sh_b4_im",  bin_im[4],  -181);
    chk("sh_b8_re",  bin_re[8],  0);
    chk("sh_b8_im",  bin_im[8],  -256);
    chk("sh_b16_re", bin_re[16], -256);
    chk("sh_b16_im", bin_im[16], 0);
`ifndef DFT_SEQ_HALF_SPECTRUM_EN
    chk("sh_b24_re", bin_re[24], 0);
    chk("sh_b24_im", bin_im[24], 256);
`endif

    // Reset at RUN k=5, n=17 (tw = 85 mod 32 = 21).
    set_frame(0);
    load_frame("abort", 1'b0, 1'b0);
    repeat (1 + 32*5 + 17) @(posedge clk);
    #1;
    chk("k5n17_b_re",  longint'($signed(mac_b_re)), -142);
    chk("k5n17_b_im",  longint'($signed(mac_b_im)), 213);
    chk("k5n17_busy",  busy, 1);
    aclr = 1'b0;
    #1;
    chk_reset("midrst");
    #1;
    aclr = 1'b1;
    @(posedge clk); #1;

    set_frame(0);
    load_frame("imp2", 1'b0, 1'b0);
    wait_done("imp2");
    frame_checks("imp2");
    impulse_values("imp2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
